hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Responder to the decode/execute pipeline register.
- Consumes that register's execute-stage outputs (Rs1E, Rs2E, RdE, MemReadE, resolved branch/jump) together with decode, memory and writeback register addresses.
- Generates the stall, flush and forwarding controls that drive the pipeline registers and the execute operand muxes.
- Adds a memory-wait freeze state machine, a wait timeout monitor, and saturating stall/flush performance counters.

Parameters:
- WIDTH, 5, register address width.
- WAIT_WIDTH, 8, width of the memory-wait cycle counter.
- TIMEOUT, 200, number of consecutive busy cycles at which Timeout is set; must be < 2^WAIT_WIDTH.
- COUNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- Rs1D  in  WIDTH  decode-stage source register 1.
- Rs2D  in  WIDTH  decode-stage source register 2.
- Rs1E  in  WIDTH  execute-stage source register 1.
- Rs2E  in  WIDTH  execute-stage source register 2.
- RdE  in  WIDTH  execute-stage destination register.
- MemReadE  in  1  load in execute.
- PCSrcE  in  1  taken branch or jump resolved in execute.
- RdM  in  WIDTH  memory-stage destination register.
- RegWriteM  in  1  memory-stage register write enable.
- RdW  in  WIDTH  writeback-stage destination register.
- RegWriteW  in  1  writeback-stage register write enable.
- MemBusyM  in  1  data memory not ready; access in memory stage must hold.
- StallF  out  1  hold PC.
- StallD  out  1  hold fetch/decode register.
- StallE  out  1  hold decode/execute register.
- StallM  out  1  hold execute/memory register.
- StallW  out  1  hold memory/writeback register.
- FlushD  out  1  bubble into fetch/decode register.
- FlushE  out  1  bubble into decode/execute register (drives its flush input).
- ForwardAE  out  2  operand A select: 00 register file, 01 writeback result, 10 memory-stage ALU result.
- ForwardBE  out  2  operand B select, same encoding as ForwardAE.
- Timeout  out  1  sticky memory-wait timeout flag.
- StallCount  out  COUNT_WIDTH  cycles with StallD=1.
- FlushCount  out  COUNT_WIDTH  cycles with FlushD=1.

Behaviour:
- Architecture: one clock. All state is updated on posedge clk; synchronous active-high reset. Hazard and forwarding outputs are combinational from inputs and state.
- Forwarding, per operand, using Rs1E for A and Rs2E for B:
  - Select 10 if RegWriteM && RdM!=0 && RdM==RsxE.
  - Else select 01 if RegWriteW && RdW!=0 && RdW==RsxE.
  - Else select 00. Memory stage has priority over writeback.
- Load-use hazard: lwStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- State machine, two states RUN and WAIT:
  - RUN, MemBusyM=0:
    - StallF = StallD = lwStall.
    - StallE = StallM = StallW = 0.
    - FlushD = PCSrcE.
    - FlushE = lwStall | PCSrcE.
    - Stay in RUN.
  - RUN, MemBusyM=1 (freeze, same cycle):
    - All five Stall outputs = 1; FlushD = FlushE = 0. Freeze overrides lwStall and PCSrcE.
    - wait_cnt <= 1; next state WAIT.
  - WAIT, MemBusyM=1:
    - Freeze outputs as above.
    - wait_cnt increments, saturating at all-ones.
    - Timeout <= 1 when wait_cnt == TIMEOUT-1 (set on the TIMEOUT-th consecutive busy cycle); stays in WAIT.
  - WAIT, MemBusyM=0 (release):
    - Outputs exactly as RUN with MemBusyM=0; the held PCSrcE and lwStall are applied this cycle.
    - wait_cnt <= 0; next state RUN.
- Because the whole pipeline is frozen, the execute and forwarding inputs are stable through WAIT. No flush is lost and none is duplicated.
- Timeout is sticky; only rst clears it. It has no effect on stall or flush outputs.
- Counters:
  - StallCount += 1 each cycle StallD=1, including freeze cycles.
  - FlushCount += 1 each cycle FlushD=1.
  - Both saturate at 2^COUNT_WIDTH-1 and never wrap.
- Reset (rst=1):
  - Next state RUN; wait_cnt, Timeout, StallCount, FlushCount <= 0.
  - While rst=1, outputs are forced: all Stall = 0, FlushD = FlushE = 1, ForwardAE = ForwardBE = 00.
  - Counters do not count during reset.
  - Reset asserted in WAIT returns to RUN on the next edge regardless of MemBusyM.
- Simultaneous events:
  - lwStall with PCSrcE: FlushD=1, FlushE=1, StallF=StallD=1 (the stall wins over the redirect for the fetch/decode register; the flushed decode is discarded).
  - x0 destination never forwards and never stalls.

Test Plan:
- Forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> 01. Then RdM=RdW=0 with both write enables 1 -> 00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0, StallCount increments by 1. With RdE=0 -> no stall.
- Branch: PCSrcE=1, no load-use -> FlushD=FlushE=1, stalls 0, FlushCount increments by 1.
- Freeze with pending branch: PCSrcE=1 and MemBusyM=1 for 3 cycles:
  - Busy cycles: all Stall=1, flushes 0.
  - Release cycle: FlushD=FlushE=1.
  - State back to RUN after release; StallCount rises by 3.
- Timeout: TIMEOUT=4, MemBusyM held 6 cycles -> Timeout rises after the 4th busy cycle. It stays 1 after release and clears only on rst.
- Reset mid-WAIT: rst=1 during busy -> next cycle state RUN, counters and Timeout zero, FlushD=FlushE=1 while rst is held. Counter saturation: COUNT_WIDTH=3 with 10 load-use stalls -> StallCount=7.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bus: execute/decode/memory/writeback hazard inputs and the
// stall, flush, forwarding and status outputs.
interface hazard_ctrl_if #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic [WIDTH-1:0]       Rs1D;
  logic [WIDTH-1:0]       Rs2D;
  logic [WIDTH-1:0]       Rs1E;
  logic [WIDTH-1:0]       Rs2E;
  logic [WIDTH-1:0]       RdE;
  logic                   MemReadE;
  logic                   PCSrcE;
  logic [WIDTH-1:0]       RdM;
  logic                   RegWriteM;
  logic [WIDTH-1:0]       RdW;
  logic                   RegWriteW;
  logic                   MemBusyM;
  logic                   StallF;
  logic                   StallD;
  logic                   StallE;
  logic                   StallM;
  logic                   StallW;
  logic                   FlushD;
  logic                   FlushE;
  logic [1:0]             ForwardAE;
  logic [1:0]             ForwardBE;
  logic                   Timeout;
  logic [COUNT_WIDTH-1:0] StallCount;
  logic [COUNT_WIDTH-1:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemBusyM,
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
           ForwardAE, ForwardBE, Timeout, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemBusyM,
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
           ForwardAE, ForwardBE, Timeout, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// memory-wait freeze with timeout monitor, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned WAIT_WIDTH  = 8,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [WAIT_WIDTH-1:0] TIMEOUT_LAST = WAIT_WIDTH'(TIMEOUT - 1);
  localparam logic                  TIMEOUT_ONE  = (TIMEOUT == 1);

  logic [0:0]            state_q, state_d;
  logic [WAIT_WIDTH-1:0] wait_cnt, wait_d;
  logic                  timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0] stall_cnt, flush_cnt;

  logic       lw_stall;
  logic       stall_f, stall_d, stall_e, stall_m, stall_w;
  logic       flush_d, flush_e;
  logic [1:0] fwd_a, fwd_b;

  assign lw_stall = bus.MemReadE && (bus.RdE != '0) &&
                    ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // Operand forwarding; memory stage wins over writeback, x0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == bus.Rs1E))      fwd_a = 2'b10;
      else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs1E)) fwd_a = 2'b01;
      if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == bus.Rs2E))      fwd_b = 2'b10;
      else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == bus.Rs2E)) fwd_b = 2'b01;
    end
  end

  // Next-state and stall/flush decode for the RUN/WAIT freeze machine.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_cnt;
    timeout_d = timeout_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    stall_w   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (rst) begin
      state_d   = S_RUN;
      wait_d    = '0;
      timeout_d = 1'b0;
      flush_d   = 1'b1;
      flush_e   = 1'b1;
    end else if (bus.MemBusyM) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
      if (state_q == S_RUN) begin
        state_d = S_WAIT;
        wait_d  = WAIT_WIDTH'(1);
        if (TIMEOUT_ONE) timeout_d = 1'b1;
      end else begin
        if (wait_cnt != '1) wait_d = wait_cnt + WAIT_WIDTH'(1);
        if (wait_cnt == TIMEOUT_LAST) timeout_d = 1'b1;
      end
    end else begin
      // Release from WAIT applies the held branch/load-use exactly once.
      stall_f = lw_stall;
      stall_d = lw_stall;
      flush_d = bus.PCSrcE;
      flush_e = lw_stall | bus.PCSrcE;
      state_d = S_RUN;
      wait_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_cnt  <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != '1)) stall_cnt <= stall_cnt + COUNT_WIDTH'(1);
      if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + COUNT_WIDTH'(1);
    end
  end

  assign bus.StallF     = stall_f;
  assign bus.StallD     = stall_d;
  assign bus.StallE     = stall_e;
  assign bus.StallM     = stall_m;
  assign bus.StallW     = stall_w;
  assign bus.FlushD     = flush_d;
  assign bus.FlushE     = flush_e;
  assign bus.ForwardAE  = fwd_a;
  assign bus.ForwardBE  = fwd_b;
  assign bus.Timeout    = timeout_q;
  assign bus.StallCount = stall_cnt;
  assign bus.FlushCount = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  localparam int unsigned WIDTH       = 5;
  localparam int unsigned WAIT_WIDTH  = 8;
  localparam int unsigned TIMEOUT     = 4;
  localparam int unsigned COUNT_WIDTH = 3;

  typedef struct packed {
    logic [4:0] st;   // F,D,E,M,W
    logic [1:0] fl;   // D,E
    logic [1:0] fa;
    logic [1:0] fb;
    logic       to;
    logic [2:0] sc;
    logic [2:0] fc;
  } exp_t;

  localparam logic [4:0] NS  = 5'b00000;
  localparam logic [4:0] LW  = 5'b11000;
  localparam logic [4:0] FRZ = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  hazard_ctrl_if #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) bus ();

  hazard_ctrl #(
    .WIDTH(WIDTH), .WAIT_WIDTH(WAIT_WIDTH),
    .TIMEOUT(TIMEOUT), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [4:0] st, input logic [1:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic to, input int sc, input int fc);
    exp_t e;
    e.st = st; e.fl = fl; e.fa = fa; e.fb = fb; e.to = to;
    e.sc = 3'(sc); e.fc = 3'(fc);
    return e;
  endfunction

  task automatic set_in(input int rs1d, input int rs2d, input int rs1e, input int rs2e,
                        input int rde, input logic memrd, input logic pcsrc,
                        input int rdm, input logic rwm, input int rdw, input logic rww,
                        input logic busy);
    bus.Rs1D = 5'(rs1d); bus.Rs2D = 5'(rs2d);
    bus.Rs1E = 5'(rs1e); bus.Rs2E = 5'(rs2e);
    bus.RdE = 5'(rde);   bus.MemReadE = memrd; bus.PCSrcE = pcsrc;
    bus.RdM = 5'(rdm);   bus.RegWriteM = rwm;
    bus.RdW = 5'(rdw);   bus.RegWriteW = rww;
    bus.MemBusyM = busy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic step(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every pending expectation against the outputs mid-cycle.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW,
              bus.FlushD, bus.FlushE, bus.ForwardAE, bus.ForwardBE,
              bus.Timeout, bus.StallCount, bus.FlushCount};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got st=%b fl=%b fa=%b fb=%b to=%b sc=%0d fc=%0d, expected st=%b fl=%b fa=%b fb=%b to=%b sc=%0d fc=%0d",
                   nm, a.st, a.fl, a.fa, a.fb, a.to, a.sc, a.fc,
                   e.st, e.fl, e.fa, e.fb, e.to, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset forces outputs even with a forwarding match present
    set_in(0, 0, 5, 5, 0, 1'b0, 1'b1, 5, 1'b1, 5, 1'b1, 1'b0);
    step("reset_forced", mk(NS, 2'b11, 2'b00, 2'b00, 1'b0, 0, 0));
    rst = 1'b0;

    // Forwarding priority
    set_in(0, 0, 5, 0, 0, 1'b0, 1'b0, 5, 1'b1, 5, 1'b1, 1'b0);
    step("fwd_mem_prio", mk(NS, 2'b00, 2'b10, 2'b00, 1'b0, 0, 0));
    set_in(0, 0, 5, 0, 0, 1'b0, 1'b0, 5, 1'b0, 5, 1'b1, 1'b0);
    step("fwd_wb", mk(NS, 2'b00, 2'b01, 2'b00, 1'b0, 0, 0));
    set_in(0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
    step("fwd_x0", mk(NS, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0));
    set_in(0, 0, 4, 9, 0, 1'b0, 1'b0, 9, 1'b1, 4, 1'b1, 1'b0);
    step("fwd_a_wb_b_mem", mk(NS, 2'b00, 2'b01, 2'b10, 1'b0, 0, 0));

    // Load-use stall, then x0 load
    set_in(0, 7, 0, 0, 7, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step("load_use", mk(LW, 2'b01, 2'b00, 2'b00, 1'b0, 0, 0));
    set_in(0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step("load_x0", mk(NS, 2'b00, 2'b00, 2'b00, 1'b0, 1, 0));

    // Branch flush
    set_in(0, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    step("branch", mk(NS, 2'b11, 2'b00, 2'b00, 1'b0, 1, 0));
    idle();
    step("after_branch", mk(NS, 2'b00, 2'b00, 2'b00, 1'b0, 1, 1));

    // Load-use together with branch
    set_in(3, 0, 0, 0, 3, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    step("lw_and_branch", mk(LW, 2'b11, 2'b00, 2'b00, 1'b0, 1, 1));
    idle();
    step("after_lw_branch", mk(NS, 2'b00, 2'b00, 2'b00, 1'b0, 2, 2));

    // Freeze with pending branch for 3 cycles, then release
    set_in(0, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1);
    step("freeze1", mk(FRZ, 2'b00, 2'b00, 2'b00, 1'b0, 2, 2));
    step("freeze2", mk(FRZ, 2'b00, 2'b00, 2'b00, 1'b0, 3, 2));
    step("freeze3", mk(FRZ, 2'b00, 2'b00, 2'b00, 1'b0, 4, 2));
    bus.MemBusyM = 1'b0;
    step("release_branch", mk(NS, 2'b11, 2'b00, 2'b00, 1'b0, 5, 2));
    idle();
    step("after_release", mk(NS, 2'b00, 2'b00, 2'b00, 1'b0, 5, 3));

    rst = 1'b1;
    step("reset_pulse", mk(NS, 2'b11, 2'b00, 2'b00, 1'b0, 5, 3));
    rst = 1'b0;

    // Timeout after the 4th consecutive busy cycle, sticky after release
    bus.MemBusyM = 1'b1;
    for (int i = 0; i < 6; i++)
      step($sformatf("timeout_busy%0d", i + 1),
           mk(FRZ, 2'b00, 2'b00, 2'b00, (i >= 4), i, 0));
    bus.MemBusyM = 1'b0;
    step("timeout_release", mk(NS, 2'b00, 2'b00, 2'b00, 1'b1, 6, 0));
    step("timeout_sticky", mk(NS, 2'b00, 2'b00, 2'b00, 1'b1, 6, 0));

    // Reset while in WAIT
    bus.MemBusyM = 1'b1;
    step("wait_again1", mk(FRZ, 2'b00, 2'b00, 2'b00, 1'b1, 6, 0));
    step("wait_again2", mk(FRZ, 2'b00, 2'b00, 2'b00, 1'b1, 7, 0));
    rst = 1'b1;
    step("rst_in_wait1", mk(NS, 2'b11, 2'b00, 2'b00, 1'b1, 7, 0));
    step("rst_in_wait2", mk(NS, 2'b11, 2'b00, 2'b00, 1'b0, 0, 0));
    rst = 1'b0;
    bus.MemBusyM = 1'b0;
    step("post_rst_run", mk(NS, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0));
    // A fresh busy run must take the full TIMEOUT cycles from RUN
    bus.MemBusyM = 1'b1;
    for (int i = 0; i < 4; i++)
      step($sformatf("post_rst_busy%0d", i + 1),
           mk(FRZ, 2'b00, 2'b00, 2'b00, 1'b0, i, 0));
    bus.MemBusyM = 1'b0;
    step("post_rst_timeout", mk(NS, 2'b00, 2'b00, 2'b00, 1'b1, 4, 0));

    // StallCount saturation with 10 load-use stalls
    rst = 1'b1;
    step("sat_reset", mk(NS, 2'b11, 2'b00, 2'b00, 1'b1, 4, 0));
    rst = 1'b0;
    set_in(7, 0, 0, 0, 7, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step($sformatf("sat_lw%0d", i + 1),
           mk(LW, 2'b01, 2'b00, 2'b00, 1'b0, (i > 7) ? 7 : i, 0));
    idle();
    step("sat_final", mk(NS, 2'b00, 2'b00, 2'b00, 1'b0, 7, 0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
